// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the RV32I multi-cycle control FSM.
// Defines the state encoding, the opcodes the FSM dispatches on, and the
// select encodings for the ALU class, ALU operand muxes and result mux.
package mc_ctrl_pkg;

  localparam int unsigned ALU_OP_W     = 2;
  localparam int unsigned RESULT_SRC_W = 2;
  localparam int unsigned STATE_W      = 4;
  localparam int unsigned OPCODE_W     = 7;
  localparam int unsigned SRC_SEL_W    = 2;

  // State encodings; also visible on the debug state output
  localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH    = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd5;
  localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd6;
  localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd7;
  localparam logic [STATE_W-1:0] S_EXEC_I   = 4'd8;
  localparam logic [STATE_W-1:0] S_ALU_WB   = 4'd9;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd10;
  localparam logic [STATE_W-1:0] S_JAL      = 4'd11;
  localparam logic [STATE_W-1:0] S_AUIPC    = 4'd12;
  localparam logic [STATE_W-1:0] S_LUI      = 4'd13;
  localparam logic [STATE_W-1:0] S_TRAP     = 4'd14;

  // Named view of the same encodings for debug/trace decoding
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = S_IDLE,
    ST_FETCH    = S_FETCH,
    ST_DECODE   = S_DECODE,
    ST_MEM_ADDR = S_MEM_ADDR,
    ST_MEM_RD   = S_MEM_RD,
    ST_MEM_WR   = S_MEM_WR,
    ST_MEM_WB   = S_MEM_WB,
    ST_EXEC_R   = S_EXEC_R,
    ST_EXEC_I   = S_EXEC_I,
    ST_ALU_WB   = S_ALU_WB,
    ST_BRANCH   = S_BRANCH,
    ST_JAL      = S_JAL,
    ST_AUIPC    = S_AUIPC,
    ST_LUI      = S_LUI,
    ST_TRAP     = S_TRAP
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_CMP   = 2'b11
  } alu_op_e;

  typedef enum logic [RESULT_SRC_W-1:0] {
    RES_ALUOUT = 2'b00,
    RES_MDR    = 2'b01,
    RES_ALU    = 2'b10
  } result_src_e;

  typedef enum logic [SRC_SEL_W-1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } alu_src_a_e;

  typedef enum logic [SRC_SEL_W-1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } alu_src_b_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM and the shared datapath.
// master: the FSM (drives enables/selects, observes opcode, mem_ready, branch_taken)
// slave : the datapath/memory side
interface multicycle_control_fsm_if;
  import mc_ctrl_pkg::*;

  logic [OPCODE_W-1:0]     opcode;
  logic                    mem_ready;
  logic                    branch_taken;
  logic                    pc_we;
  logic                    ir_we;
  logic                    reg_we;
  logic                    mem_req;
  logic                    mem_we;
  logic                    adr_src;
  logic [SRC_SEL_W-1:0]    alu_src_a;
  logic [SRC_SEL_W-1:0]    alu_src_b;
  logic [RESULT_SRC_W-1:0] result_src;
  logic [ALU_OP_W-1:0]     alu_op;

  modport master (
    input  opcode, mem_ready, branch_taken,
    output pc_we, ir_we, reg_we, mem_req, mem_we, adr_src,
           alu_src_a, alu_src_b, result_src, alu_op
  );

  modport slave (
    output opcode, mem_ready, branch_taken,
    input  pc_we, ir_we, reg_we, mem_req, mem_we, adr_src,
           alu_src_a, alu_src_b, result_src, alu_op
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore-style control FSM for the RV32I multi-cycle core.
// Sequences FETCH, DECODE, then EXECUTE/MEM/WB states and drives every enable
// and mux select of the shared datapath; memory uses a mem_req/mem_ready handshake.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   ctrl           control bundle (master side): opcode/mem_ready/branch_taken in,
//                  pc_we/ir_we/reg_we/mem_req/mem_we/adr_src/alu_src_a/alu_src_b/
//                  result_src/alu_op out
//   state_o        current state encoding, debug only
//   illegal_instr  (MC_CTRL_TRAP_EN only) high while parked in the trap state
// Build option:
//   MC_CTRL_TRAP_EN  illegal opcode enters a sticky trap state left only via rst_n;
//                    without it an illegal opcode retires as a NOP.
// Outputs decode the state register directly (plus mem_ready in the memory
// states and branch_taken in S_BRANCH), so an async reset clears them at once.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  ctrl,
  output logic [STATE_W-1:0]        state_o
`ifdef MC_CTRL_TRAP_EN
  ,
  output logic                      illegal_instr
`endif
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d         = state_q;
    ctrl.pc_we      = 1'b0;
    ctrl.ir_we      = 1'b0;
    ctrl.reg_we     = 1'b0;
    ctrl.mem_req    = 1'b0;
    ctrl.mem_we     = 1'b0;
    ctrl.adr_src    = 1'b0;
    ctrl.alu_src_a  = SRC_A_PC;
    ctrl.alu_src_b  = SRC_B_RS2;
    ctrl.result_src = RES_ALUOUT;
    ctrl.alu_op     = ALU_ADD;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 computed alongside the instruction read; both commit on mem_ready
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.result_src = RES_ALU;
        if (ctrl.mem_ready) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_d    = S_DECODE;
        end
      end

      // OldPC+imm lands in ALUOut for a later branch/JAL target
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        case (ctrl.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
`ifdef MC_CTRL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end

      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d = (ctrl.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (ctrl.mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.adr_src = 1'b1;
        if (ctrl.mem_ready) state_d = S_FETCH;
      end

      S_MEM_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.result_src = RES_MDR;
        state_d         = S_FETCH;
      end

      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_ALU_WB;
      end

      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_ALU_WB;
      end

      S_ALU_WB: begin
        ctrl.reg_we = 1'b1;
        state_d     = S_FETCH;
      end

      // Target already in ALUOut; PC loads only if the comparator agrees
      S_BRANCH: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_CMP;
        ctrl.pc_we     = ctrl.branch_taken;
        state_d        = S_FETCH;
      end

      // PC <= target from ALUOut while OldPC+4 refills ALUOut for the link write
      S_JAL: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.pc_we     = 1'b1;
        state_d        = S_ALU_WB;
      end

      S_AUIPC: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d        = S_ALU_WB;
      end

      // Decoder guarantees rs1 = x0, so rs1+imm yields the upper immediate
      S_LUI: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_d        = S_ALU_WB;
      end

      // Sticky until reset; all controls stay low
      S_TRAP: state_d = S_TRAP;

      default: state_d = S_IDLE;
    endcase
  end

  assign state_o = state_q;

`ifdef MC_CTRL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: a per-cycle vector table
// covering lw/add/sw/beq/addi/jal/auipc/lui, then hand-written sequences for
// the illegal opcode and an asynchronous reset in the middle of a store.
module tb_multicycle_control_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [STATE_W-1:0] state_o;
`ifdef MC_CTRL_TRAP_EN
  logic illegal_instr;
`endif

  multicycle_control_fsm_if bus();

  multicycle_control_fsm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl    (bus.master),
    .state_o (state_o)
`ifdef MC_CTRL_TRAP_EN
    ,
    .illegal_instr (illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  // Control word: pc_we ir_we reg_we mem_req mem_we adr_src | a | b | result_src | alu_op
  logic [13:0] act_cw;
  assign act_cw = {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_req, bus.mem_we, bus.adr_src,
                   bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_op};

  localparam logic [13:0] W_ZERO  = 14'd0;
  localparam logic [13:0] W_FWAIT = {6'b000100, 2'b00, 2'b10, 2'b10, 2'b00};
  localparam logic [13:0] W_FRDY  = {6'b110100, 2'b00, 2'b10, 2'b10, 2'b00};
  localparam logic [13:0] W_DEC   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [13:0] W_MADDR = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [13:0] W_MRD   = {6'b000101, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] W_MWR   = {6'b000111, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] W_MWB   = {6'b001000, 2'b00, 2'b00, 2'b01, 2'b00};
  localparam logic [13:0] W_EXR   = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b10};
  localparam logic [13:0] W_EXI   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b10};
  localparam logic [13:0] W_AWB   = {6'b001000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] W_BRT   = {6'b100000, 2'b10, 2'b00, 2'b00, 2'b11};
  localparam logic [13:0] W_BRN   = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b11};
  localparam logic [13:0] W_JAL   = {6'b100000, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [13:0] W_AUI   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [13:0] W_LUI   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00};

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic        bt;
    logic [3:0]  st;
    logic [13:0] cw;
  } vec_t;

  vec_t vecs[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic [6:0] op, input logic rdy, input logic bt,
                     input logic [3:0] st, input logic [13:0] cw);
    vec_t v;
    v.op = op; v.rdy = rdy; v.bt = bt; v.st = st; v.cw = cw;
    vecs.push_back(v);
  endtask

  // Entered just after a rising edge; drives inputs, checks, advances one cycle
  task automatic run_vec(input int idx, input vec_t v);
    bus.opcode       = v.op;
    bus.mem_ready    = v.rdy;
    bus.branch_taken = v.bt;
    #2;
    chk($sformatf("vec%0d state", idx), 32'(state_o), 32'(v.st));
    chk($sformatf("vec%0d ctrl", idx), 32'(act_cw), 32'(v.cw));
    @(posedge clk); #1;
  endtask

  // Reset pulse; leaves the FSM in S_FETCH, just after a rising edge
  task automatic do_reset(input string tag);
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk({tag, " rst state"}, 32'(state_o), 32'(S_IDLE));
    chk({tag, " rst ctrl"}, 32'(act_cw), 32'(W_ZERO));
`ifdef MC_CTRL_TRAP_EN
    chk({tag, " rst illegal"}, 32'(illegal_instr), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    chk({tag, " idle state"}, 32'(state_o), 32'(S_IDLE));
    chk({tag, " idle ctrl"}, 32'(act_cw), 32'(W_ZERO));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;

    // lw with two wait cycles on each access
    add(OP_LOAD, 1'b0, 1'b0, S_FETCH,    W_FWAIT);
    add(OP_LOAD, 1'b0, 1'b0, S_FETCH,    W_FWAIT);
    add(OP_LOAD, 1'b1, 1'b0, S_FETCH,    W_FRDY);
    add(OP_LOAD, 1'b0, 1'b0, S_DECODE,   W_DEC);
    add(OP_LOAD, 1'b0, 1'b0, S_MEM_ADDR, W_MADDR);
    add(OP_LOAD, 1'b0, 1'b0, S_MEM_RD,   W_MRD);
    add(OP_LOAD, 1'b0, 1'b0, S_MEM_RD,   W_MRD);
    add(OP_LOAD, 1'b1, 1'b0, S_MEM_RD,   W_MRD);
    add(OP_LOAD, 1'b1, 1'b0, S_MEM_WB,   W_MWB);
    // add, memory always ready
    add(OP_R,    1'b1, 1'b0, S_FETCH,    W_FRDY);
    add(OP_R,    1'b1, 1'b0, S_DECODE,   W_DEC);
    add(OP_R,    1'b1, 1'b0, S_EXEC_R,   W_EXR);
    add(OP_R,    1'b1, 1'b0, S_ALU_WB,   W_AWB);
    // sw, three wait cycles on the write
    add(OP_STORE, 1'b1, 1'b0, S_FETCH,    W_FRDY);
    add(OP_STORE, 1'b0, 1'b0, S_DECODE,   W_DEC);
    add(OP_STORE, 1'b0, 1'b0, S_MEM_ADDR, W_MADDR);
    add(OP_STORE, 1'b0, 1'b0, S_MEM_WR,   W_MWR);
    add(OP_STORE, 1'b0, 1'b0, S_MEM_WR,   W_MWR);
    add(OP_STORE, 1'b0, 1'b0, S_MEM_WR,   W_MWR);
    add(OP_STORE, 1'b1, 1'b0, S_MEM_WR,   W_MWR);
    // beq taken, then not taken
    add(OP_BRANCH, 1'b1, 1'b1, S_FETCH,  W_FRDY);
    add(OP_BRANCH, 1'b1, 1'b1, S_DECODE, W_DEC);
    add(OP_BRANCH, 1'b1, 1'b1, S_BRANCH, W_BRT);
    add(OP_BRANCH, 1'b1, 1'b0, S_FETCH,  W_FRDY);
    add(OP_BRANCH, 1'b1, 1'b0, S_DECODE, W_DEC);
    add(OP_BRANCH, 1'b1, 1'b0, S_BRANCH, W_BRN);
    // addi
    add(OP_I,    1'b1, 1'b0, S_FETCH,  W_FRDY);
    add(OP_I,    1'b1, 1'b0, S_DECODE, W_DEC);
    add(OP_I,    1'b1, 1'b0, S_EXEC_I, W_EXI);
    add(OP_I,    1'b1, 1'b0, S_ALU_WB, W_AWB);
    // jal
    add(OP_JAL,  1'b1, 1'b0, S_FETCH,  W_FRDY);
    add(OP_JAL,  1'b1, 1'b0, S_DECODE, W_DEC);
    add(OP_JAL,  1'b1, 1'b0, S_JAL,    W_JAL);
    add(OP_JAL,  1'b1, 1'b0, S_ALU_WB, W_AWB);
    // auipc
    add(OP_AUIPC, 1'b1, 1'b0, S_FETCH,  W_FRDY);
    add(OP_AUIPC, 1'b1, 1'b0, S_DECODE, W_DEC);
    add(OP_AUIPC, 1'b1, 1'b0, S_AUIPC,  W_AUI);
    add(OP_AUIPC, 1'b1, 1'b0, S_ALU_WB, W_AWB);
    // lui
    add(OP_LUI,  1'b1, 1'b0, S_FETCH,  W_FRDY);
    add(OP_LUI,  1'b1, 1'b0, S_DECODE, W_DEC);
    add(OP_LUI,  1'b1, 1'b0, S_LUI,    W_LUI);
    add(OP_LUI,  1'b1, 1'b0, S_ALU_WB, W_AWB);

    #1;
    do_reset("init");
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Illegal opcode 7'h7F
    v.op = 7'h7F; v.rdy = 1'b1; v.bt = 1'b0; v.st = S_FETCH;  v.cw = W_FRDY; run_vec(100, v);
    v.rdy = 1'b0;                             v.st = S_DECODE; v.cw = W_DEC;  run_vec(101, v);
`ifdef MC_CTRL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1;
      #2;
      chk($sformatf("trap%0d state", i), 32'(state_o), 32'(S_TRAP));
      chk($sformatf("trap%0d ctrl", i), 32'(act_cw), 32'(W_ZERO));
      chk($sformatf("trap%0d illegal", i), 32'(illegal_instr), 32'd1);
      @(posedge clk); #1;
    end
`else
    v.st = S_FETCH; v.cw = W_FWAIT; run_vec(102, v);
`endif

    // Async reset in the middle of a pending store
    do_reset("pre_sw");
    v.op = OP_STORE; v.rdy = 1'b1; v.st = S_FETCH;    v.cw = W_FRDY;  run_vec(110, v);
    v.rdy = 1'b0;                  v.st = S_DECODE;   v.cw = W_DEC;   run_vec(111, v);
                                   v.st = S_MEM_ADDR; v.cw = W_MADDR; run_vec(112, v);
    #2;
    chk("midwr state", 32'(state_o), 32'(S_MEM_WR));
    chk("midwr req", 32'(bus.mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst state", 32'(state_o), 32'(S_IDLE));
    @(posedge clk); #1;
    chk("rst held state", 32'(state_o), 32'(S_IDLE));
    rst_n = 1'b1;
    #2;
    chk("post rst idle", 32'(state_o), 32'(S_IDLE));
    chk("post rst ctrl", 32'(act_cw), 32'(W_ZERO));
    @(posedge clk); #1;
    chk("post rst fetch", 32'(state_o), 32'(S_FETCH));
    chk("post rst fetch ctrl", 32'(act_cw), 32'(W_FWAIT));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
